// File: rtl/reg_file_sb.sv
// Register file with per-register pending scoreboard, write-to-read bypass
// and a hardware clear sequencer that zeroes one register per cycle.
module reg_file_sb #(
  parameter int DW      = 8,
  parameter int AW      = 3,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] dat_in,
  input  logic [AW-1:0] rd_addrA,
  input  logic [AW-1:0] rd_addrB,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          rdA_rdy,
  output logic          rdB_rdy,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_addr,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          wr_drop
);
  // state | meaning
  // IDLE  | normal operation, writes and reserves accepted
  // SWEEP | clearing regs[cnt] each cycle, writes dropped, reserves ignored
  typedef enum logic [0:0] {IDLE, SWEEP} state_t;

  localparam int DEPTH = 2 ** AW;

  state_t            state;
  logic [AW-1:0]     cnt;
  logic [DW-1:0]     regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              wr_acc;
  logic              rsv_acc;

  always_comb begin
    wr_acc  = wr_en  && !clr_busy && !(ZERO_R0 != 0 && wr_addr == '0);
    rsv_acc = rsv_en && !clr_busy && !(ZERO_R0 != 0 && rsv_addr == '0);
  end

  always_comb begin
    datA_out = regs[rd_addrA];
    rdA_rdy  = !pend[rd_addrA];
    if (ZERO_R0 != 0 && rd_addrA == '0) begin
      datA_out = '0;
      rdA_rdy  = 1'b1;
    end else if (BYPASS != 0 && wr_acc && wr_addr == rd_addrA) begin
      datA_out = dat_in;
      rdA_rdy  = 1'b1;
    end
  end

  always_comb begin
    datB_out = regs[rd_addrB];
    rdB_rdy  = !pend[rd_addrB];
    if (ZERO_R0 != 0 && rd_addrB == '0) begin
      datB_out = '0;
      rdB_rdy  = 1'b1;
    end else if (BYPASS != 0 && wr_acc && wr_addr == rd_addrB) begin
      datB_out = dat_in;
      rdB_rdy  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pend     <= '0;
      state    <= IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      wr_drop <= wr_en && clr_busy;
      if (wr_acc) begin
        regs[wr_addr] <= dat_in;
        pend[wr_addr] <= 1'b0;
      end
      // Reserve is applied after the write so a same-edge pair stays pending.
      if (rsv_acc) pend[rsv_addr] <= 1'b1;
      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= SWEEP;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        SWEEP: begin
          regs[cnt] <= '0;
          pend[cnt] <= 1'b0;
          cnt       <= cnt + 1'b1;
          if (cnt == '1) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: one default instance plus one with
// ZERO_R0=1 / BYPASS=0, both driven by the same stimulus.
module tb_reg_file_sb;
  logic       clk = 1'b0;
  logic       reset, wr_en, rsv_en, clr_start;
  logic [2:0] wr_addr, rd_addrA, rd_addrB, rsv_addr;
  logic [7:0] dat_in;
  logic [7:0] datA_out, datB_out, z_datA, z_datB;
  logic       rdA_rdy, rdB_rdy, clr_busy, wr_drop;
  logic       z_rdA, z_rdB, z_busy, z_wr_drop;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DW(8), .AW(3), .ZERO_R0(0), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .datA_out(datA_out), .datB_out(datB_out),
    .rdA_rdy(rdA_rdy), .rdB_rdy(rdB_rdy), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_start(clr_start), .clr_busy(clr_busy), .wr_drop(wr_drop));

  reg_file_sb #(.DW(8), .AW(3), .ZERO_R0(1), .BYPASS(0)) u_z (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .dat_in(dat_in),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB), .datA_out(z_datA), .datB_out(z_datB),
    .rdA_rdy(z_rdA), .rdB_rdy(z_rdB), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_start(clr_start), .clr_busy(z_busy), .wr_drop(z_wr_drop));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; wr_en = 1'b0; rsv_en = 1'b0; clr_start = 1'b0;
    wr_addr = '0; rd_addrA = '0; rd_addrB = '0; rsv_addr = '0; dat_in = '0;
    tick(); tick();
    reset = 1'b1;

    // reset clears prior contents
    wr_en = 1'b1; wr_addr = 3'd1; dat_in = 8'h11;
    tick();
    wr_en = 1'b0; rd_addrA = 3'd1; rd_addrB = 3'd2;
    #1 chk("prefill_r1", datA_out, 8'h11);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("rst_datA", datA_out, 8'h00);
    chk("rst_rdA", rdA_rdy, 1'b1);
    chk("rst_rdB", rdB_rdy, 1'b1);
    chk("rst_busy", clr_busy, 1'b0);
    chk("rst_drop", wr_drop, 1'b0);

    // write r3 with bypass vs. no bypass
    wr_en = 1'b1; wr_addr = 3'd3; dat_in = 8'hA5; rd_addrA = 3'd3; rd_addrB = 3'd3;
    #1;
    chk("byp_datA", datA_out, 8'hA5);
    chk("byp_rdA", rdA_rdy, 1'b1);
    chk("nobyp_datA", z_datA, 8'h00);
    tick();
    wr_en = 1'b0;
    #1;
    chk("wr_r3_A", datA_out, 8'hA5);
    chk("wr_r3_B", datB_out, 8'hA5);
    chk("wr_r3_z", z_datA, 8'hA5);

    // reserve r5, resolve with write, then simultaneous write+reserve
    rsv_en = 1'b1; rsv_addr = 3'd5;
    tick();
    rsv_en = 1'b0; rd_addrA = 3'd5;
    #1;
    chk("rsv_rdA", rdA_rdy, 1'b0);
    chk("rsv_rdA_z", z_rdA, 1'b0);
    wr_en = 1'b1; wr_addr = 3'd5; dat_in = 8'h3C;
    #1;
    chk("rsv_byp_rdA", rdA_rdy, 1'b1);
    chk("rsv_byp_datA", datA_out, 8'h3C);
    chk("rsv_nobyp_rdA", z_rdA, 1'b0);
    tick();
    wr_en = 1'b1; wr_addr = 3'd5; dat_in = 8'h77; rsv_en = 1'b1; rsv_addr = 3'd5;
    tick();
    wr_en = 1'b0; rsv_en = 1'b0;
    #1;
    chk("wr_rsv_rdA", rdA_rdy, 1'b0);
    chk("wr_rsv_datA", datA_out, 8'h77);

    // register 0 handling
    wr_en = 1'b1; wr_addr = 3'd0; dat_in = 8'hFF;
    tick();
    wr_en = 1'b0;
    #1 chk("r0_drop_z", z_wr_drop, 1'b0);
    rsv_en = 1'b1; rsv_addr = 3'd0;
    tick();
    rsv_en = 1'b0; rd_addrA = 3'd0;
    #1;
    chk("r0_dat_z", z_datA, 8'h00);
    chk("r0_rdy_z", z_rdA, 1'b1);
    chk("r0_dat", datA_out, 8'hFF);
    chk("r0_rdy", rdA_rdy, 1'b0);

    // fill then sweep
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); dat_in = 8'(8'h10 + i);
      tick();
    end
    wr_en = 1'b0; rd_addrA = 3'd7;
    #1 chk("fill_r7", datA_out, 8'h17);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    #1 chk("sweep_busy0", clr_busy, 1'b1);
    for (int k = 0; k < 8; k++) begin
      rd_addrA = 3'(k); rd_addrB = 3'd6;
      wr_en = (k == 3); wr_addr = 3'd6; dat_in = 8'hEE;
      clr_start = (k == 2);
      #1;
      chk($sformatf("sweep_pre_r%0d", k), datA_out, 32'(8'h10 + k));
      if (k == 3) chk("sweep_nobyp_r6", datB_out, 8'h16);
      tick();
      wr_en = 1'b0; clr_start = 1'b0;
      #1;
      chk($sformatf("sweep_post_r%0d", k), datA_out, 8'h00);
      chk($sformatf("sweep_busy_%0d", k), clr_busy, 32'(k < 7));
      chk($sformatf("sweep_drop_%0d", k), wr_drop, 32'(k == 3));
    end
    wr_en = 1'b1; wr_addr = 3'd6; dat_in = 8'h66;
    tick();
    wr_en = 1'b0; rd_addrA = 3'd6;
    #1;
    chk("post_sweep_wr", datA_out, 8'h66);
    chk("post_sweep_drop", wr_drop, 1'b0);

    // reset in the middle of a sweep
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick(); tick(); tick(); tick();
    #1 chk("mid_busy", clr_busy, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_busy", clr_busy, 1'b0);
    chk("midrst_r6", datA_out, 8'h00);
    wr_en = 1'b1; wr_addr = 3'd4; dat_in = 8'h44;
    tick();
    wr_en = 1'b0; rd_addrA = 3'd4;
    #1;
    chk("midrst_wr", datA_out, 8'h44);
    chk("midrst_drop", wr_drop, 1'b0);
    chk("midrst_busy2", clr_busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with per-register scoreboard, write-to-read bypass and a hardware clear sequencer. It holds the datapath's architectural registers: one write port from write-back, two combinational read ports for operand fetch, and a ready flag per read port so issue logic can stall on pending results. It generalises the 8x8 register file to arbitrary width and depth.

## Interface
- DW, 8, data width in bits
- AW, 3, address width; depth = 2**AW registers
- ZERO_R0, 0, 1 = register 0 reads as zero, ignores writes, is never pending
- BYPASS, 1, 1 = an accepted write is forwarded to a same-address read in the same cycle
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- wr_en  in  1  write request
- wr_addr  in  AW  write address
- dat_in  in  DW  write data
- rd_addrA, rd_addrB  in  AW  read addresses
- datA_out, datB_out  out  DW  read data, combinational
- rdA_rdy, rdB_rdy  out  1  read operand not pending, combinational
- rsv_en  in  1  reserve: mark rsv_addr pending
- rsv_addr  in  AW  register to reserve
- clr_start  in  1  start clear sweep
- clr_busy  out  1  clear sweep in progress, registered
- wr_drop  out  1  one-cycle pulse: previous-cycle write was discarded, registered

## Operation
- State: regs[2**AW] of DW bits, pend[2**AW] bits, FSM {IDLE, SWEEP}, sweep counter cnt (AW bits).
- Reset (reset==0 at edge): all regs=0, all pend=0, FSM=IDLE, cnt=0, clr_busy=0, wr_drop=0. Reset overrides everything, including a sweep in progress.
- Write accepted = wr_en && !clr_busy && !(ZERO_R0 && wr_addr==0). Accepted write: regs[wr_addr]<=dat_in, pend[wr_addr]<=0.
- wr_en while clr_busy: write discarded, wr_drop=1 next cycle; otherwise wr_drop=0 next cycle. Writes to r0 with ZERO_R0 are silently ignored (no wr_drop).
- Reserve accepted = rsv_en && !clr_busy && !(ZERO_R0 && rsv_addr==0): pend[rsv_addr]<=1. rsv_en while busy ignored.
- Same-edge write and reserve to same address: reserve wins (pend=1, data written).
- Read X: if ZERO_R0 && addr==0 -> data 0, rdy 1. Else if BYPASS && accepted write && wr_addr==addr -> data=dat_in, rdy=1. Else data=regs[addr], rdy=!pend[addr].
- FSM IDLE: clr_start -> SWEEP, cnt<=0, clr_busy<=1. A write accepted in that same cycle still occurs (and is later cleared).
- FSM SWEEP: each edge regs[cnt]<=0, pend[cnt]<=0, cnt<=cnt+1; when cnt==2**AW-1, -> IDLE, clr_busy<=0. clr_start in SWEEP ignored.
- Reads during SWEEP return current (partially cleared) contents; bypass never applies (no accepted writes).

## Timing
- Read latency 0 (combinational); write visible at read port the cycle after the accepting edge, or same cycle via bypass.
- Reserve visible on rdy the cycle after the sampling edge.
- clr_start sampled at edge N: clr_busy=1 from N+1 through N+2**AW; regs[i]=0 after edge N+1+i; clr_busy=0 and writes accepted again from edge N+1+2**AW.
- wr_drop: high exactly one cycle, after the edge that sampled the dropped write.

## Test plan
- Reset with prior non-zero contents, reset=0 for 1 edge -> all reads 0, rdA_rdy=rdB_rdy=1, clr_busy=0, wr_drop=0.
- Write r3=0xA5, read A=3,B=3 next cycle -> both 0xA5; same-cycle read of r3 during write -> 0xA5 with BYPASS=1, old value with BYPASS=0.
- rsv_en r5 -> rdA_rdy=0 for rd_addrA=5 next cycle; write r5=0x3C -> rdA_rdy=1 and datA_out=0x3C in the write cycle (BYPASS=1); simultaneous write+reserve r5 -> pending stays 1.
- ZERO_R0=1: write r0=0xFF, rsv_en r0 -> read r0 gives 0, rdy=1, wr_drop=0.
- Fill all regs, pulse clr_start (AW=3) -> clr_busy high 8 cycles, regs[i]=0 after edge N+1+i, wr_en mid-sweep -> wr_drop=1 one cycle, data not written; second clr_start mid-sweep ignored.
- Assert reset=0 at sweep cycle 4 -> clr_busy=0 next cycle, all regs 0, FSM idle, subsequent write accepted.
